logic_sweep_ctrl: RTL and testbench

- Sequencer for the 4-input AND/OR logic unit: on a start pulse it drives every input vector 0..15 onto the unit's inputs in order.
- For each vector it waits a programmable settle time, then samples both unit outputs into truth-table registers.
- It checks each sample against the golden function: OR output = |vec, AND output = &vec.
- It sits between a host/bench and the logic unit and replaces the free-running counter stimulus with a self-checking, handshaked sweep.

---
 rtl/logic_sweep_pkg.sv | 14 +
 rtl/logic_sweep_golden.sv | 13 +
 rtl/logic_sweep_ctrl.sv | 121 ++++++++++++
 tb/tb_logic_sweep_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_sweep_pkg.sv
// Shared definitions for the logic-unit sweep sequencer: state encoding
// and settle-counter sizing.
package logic_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int SETTLE_W = 4;

endpackage

// File: rtl/logic_sweep_golden.sv
// Golden model of the logic unit; swap this module when the unit's function changes.
module logic_sweep_golden #(
  parameter int N_IN = 4
) (
  input  logic [N_IN-1:0] vec,
  output logic            exp_or,
  output logic            exp_and
);

  assign exp_or  = |vec;
  assign exp_and = &vec;

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Sweeps every input vector through the AND/OR unit, captures both outputs
// into truth tables and counts mismatches against the golden function.
module logic_sweep_ctrl
  import logic_sweep_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iStart,
  input  logic                 iAbort,
  input  logic                 iOR_res,
  input  logic                 iAND_res,
  output logic [N_IN-1:0]      oVec,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2**N_IN-1:0]   oTT_OR,
  output logic [2**N_IN-1:0]   oTT_AND,
  output logic [N_IN:0]        oErrCnt
);

  localparam logic [N_IN-1:0]     VEC_LAST   = {N_IN{1'b1}};
  localparam logic [N_IN:0]       ERR_MAX    = {(N_IN+1){1'b1}};
  localparam logic [SETTLE_W-1:0] SETTLE_LIM = SETTLE_W'(SETTLE);

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                exp_or;
  logic                exp_and;
  logic [1:0]          miss;
  logic [N_IN+1:0]     err_sum;
  logic [N_IN:0]       err_next;

  logic_sweep_golden #(.N_IN(N_IN)) u_golden (
    .vec     (oVec),
    .exp_or  (exp_or),
    .exp_and (exp_and)
  );

  // Mismatch count for the vector being sampled, with saturating accumulate.
  always_comb begin
    miss    = {1'b0, (iOR_res != exp_or)} + {1'b0, (iAND_res != exp_and)};
    err_sum = {1'b0, oErrCnt} + {{N_IN{1'b0}}, miss};
    if (err_sum > {1'b0, ERR_MAX}) begin
      err_next = ERR_MAX;
    end else begin
      err_next = err_sum[N_IN:0];
    end
  end

  // Sweep FSM with registered vector, status, tables and error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      oVec       <= '0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oTT_OR     <= '0;
      oTT_AND    <= '0;
      oErrCnt    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // Abort has priority over start, so a simultaneous pair is a no-op.
          if (iStart && !iAbort) begin
            state      <= ST_DRIVE;
            settle_cnt <= '0;
            oVec       <= '0;
            oBusy      <= 1'b1;
            oDone      <= 1'b0;
            oTT_OR     <= '0;
            oTT_AND    <= '0;
            oErrCnt    <= '0;
          end
        end
        ST_DRIVE: begin
          if (iAbort) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            oVec       <= '0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
            if (settle_cnt == SETTLE_LIM - 4'd1) begin
              state <= ST_SAMPLE;
            end
          end
        end
        ST_SAMPLE: begin
          if (iAbort) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            oVec       <= '0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
          end else begin
            oTT_OR[oVec]  <= iOR_res;
            oTT_AND[oVec] <= iAND_res;
            oErrCnt       <= err_next;
            settle_cnt    <= '0;
            if (oVec == VEC_LAST) begin
              state <= ST_DONE;
              oBusy <= 1'b0;
              oDone <= 1'b1;
            end else begin
              state <= ST_DRIVE;
              oVec  <= oVec + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Directed bench for logic_sweep_ctrl: behavioural logic unit with fault modes,
// scoreboard of expected sweep results, SETTLE=1 and SETTLE=3 instances.
module tb_logic_sweep_ctrl;

  typedef struct {
    logic [15:0] tt_or;
    logic [15:0] tt_and;
    logic [4:0]  err;
    int          edge_n;
  } exp_t;

  logic        clk;
  logic        rst1_n, start1, abort1, or1, and1, busy1, done1;
  logic [3:0]  vec1;
  logic [15:0] ttor1, ttand1;
  logic [4:0]  err1;
  logic        rst3_n, start3, abort3, or3, and3, busy3, done3;
  logic [3:0]  vec3;
  logic [15:0] ttor3, ttand3;
  logic [4:0]  err3;
  logic [1:0]  mode;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  // mode 0: correct unit, 1: OR stuck at 1, 2: both outputs inverted
  assign or1  = (mode == 2'd1) ? 1'b1 : (mode == 2'd2) ? ~(|vec1) : (|vec1);
  assign and1 = (mode == 2'd2) ? ~(&vec1) : (&vec1);
  assign or3  = |vec3;
  assign and3 = &vec3;

  logic_sweep_ctrl #(.N_IN(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .iStart(start1), .iAbort(abort1),
    .iOR_res(or1), .iAND_res(and1), .oVec(vec1), .oBusy(busy1), .oDone(done1),
    .oTT_OR(ttor1), .oTT_AND(ttand1), .oErrCnt(err1)
  );

  logic_sweep_ctrl #(.N_IN(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .iStart(start3), .iAbort(abort3),
    .iOR_res(or3), .iAND_res(and3), .oVec(vec3), .oBusy(busy3), .oDone(done3),
    .oTT_OR(ttor3), .oTT_AND(ttand3), .oErrCnt(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] o, input logic [15:0] a, input logic [4:0] e, input int n);
    exp_t x;
    x.tt_or = o; x.tt_and = a; x.err = e; x.edge_n = n;
    sb.push_back(x);
  endtask

  task automatic pop_cmp(input string tag, input logic [15:0] o, input logic [15:0] a,
                         input logic [4:0] e, input int n);
    exp_t x;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk({tag, "_tt_or"}, 32'(o), 32'(x.tt_or));
      chk({tag, "_tt_and"}, 32'(a), 32'(x.tt_and));
      chk({tag, "_err"}, 32'(e), 32'(x.err));
      chk({tag, "_done_edge"}, 32'(n), 32'(x.edge_n));
    end
  endtask

  // Runs dut1 until oDone, checking oVec = n/2 each cycle; optionally pokes iStart at a vector.
  task automatic wait_done1(input int poke, output int n, output int verr);
    bit poked;
    poked = 1'b0; n = 0; verr = 0;
    while (done1 !== 1'b1 && n < 200) begin
      if (vec1 !== 4'(n / 2)) verr++;
      if (!poked && poke < 16 && vec1 == 4'(poke)) begin
        start1 = 1'b1;
        poked  = 1'b1;
      end
      tick();
      start1 = 1'b0;
      n++;
    end
  endtask

  task automatic wait_done3(output int n, output int verr);
    n = 0; verr = 0;
    while (done3 !== 1'b1 && n < 400) begin
      if (vec3 !== 4'(n / 4)) verr++;
      tick();
      n++;
    end
  endtask

  task automatic sweep1(input string tag, input int poke);
    int n, verr;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk({tag, "_busy"}, 32'(busy1), 32'd1);
    wait_done1(poke, n, verr);
    chk({tag, "_vec_seq"}, 32'(verr), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy1), 32'd0);
    chk({tag, "_vec_last"}, 32'(vec1), 32'd15);
    pop_cmp(tag, ttor1, ttand1, err1, n);
  endtask

  initial begin
    int n, verr, guard;
    mode = 2'd0;
    rst1_n = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    rst3_n = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    #3;
    chk("rst_vec", 32'(vec1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_tt", 32'({ttor1, ttand1}), 32'd0);
    chk("rst_err", 32'(err1), 32'd0);
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    tick();

    mode = 2'd0;
    push(16'hFFFE, 16'h8000, 5'd0, 32);
    sweep1("good", 99);

    mode = 2'd1;
    push(16'hFFFF, 16'h8000, 5'd1, 32);
    sweep1("or_stuck", 99);

    mode = 2'd2;
    push(16'h0001, 16'h7FFF, 5'd31, 32);
    sweep1("inverted", 99);

    // Abort while vector 5 is in DRIVE
    mode = 2'd0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    guard = 0;
    while (vec1 !== 4'd5 && guard < 100) begin
      tick();
      guard++;
    end
    chk("abort_reach_vec5", 32'(vec1), 32'd5);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    chk("abort_vec", 32'(vec1), 32'd0);
    chk("abort_tt_or", 32'(ttor1), 32'h001E);
    chk("abort_tt_and", 32'(ttand1), 32'h0000);
    chk("abort_err", 32'(err1), 32'd0);
    tick();
    chk("abort_idle_vec", 32'(vec1), 32'd0);

    // Restart clears tables; an extra iStart at vec 3 must not disturb timing
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("restart_tt_cleared", 32'(ttor1), 32'd0);
    chk("restart_busy", 32'(busy1), 32'd1);
    push(16'hFFFE, 16'h8000, 5'd0, 32);
    wait_done1(3, n, verr);
    chk("restart_vec_seq", 32'(verr), 32'd0);
    pop_cmp("restart", ttor1, ttand1, err1, n);

    start1 = 1'b1;
    abort1 = 1'b1;
    tick();
    start1 = 1'b0;
    abort1 = 1'b0;
    chk("start_abort_done", 32'(done1), 32'd1);
    chk("start_abort_busy", 32'(busy1), 32'd0);
    chk("start_abort_vec", 32'(vec1), 32'd15);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("abort_in_done", 32'(done1), 32'd1);

    // SETTLE=3: asynchronous reset mid-sweep, then a full sweep
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    guard = 0;
    while (vec3 !== 4'd9 && guard < 200) begin
      tick();
      guard++;
    end
    chk("s3_reach_vec9", 32'(vec3), 32'd9);
    #2;
    rst3_n = 1'b0;
    #1;
    chk("s3_async_vec", 32'(vec3), 32'd0);
    chk("s3_async_busy", 32'(busy3), 32'd0);
    chk("s3_async_tt_or", 32'(ttor3), 32'd0);
    chk("s3_async_err", 32'(err3), 32'd0);
    #1;
    rst3_n = 1'b1;
    tick();
    push(16'hFFFE, 16'h8000, 5'd0, 64);
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    wait_done3(n, verr);
    chk("s3_vec_seq", 32'(verr), 32'd0);
    chk("s3_busy_end", 32'(busy3), 32'd0);
    pop_cmp("s3", ttor3, ttand3, err3, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
